// File: rtl/mandelbrot_fb_writer.sv
// ---------------------------------------------------------------------------
// mandelbrot_fb_writer
//
// Downstream consumer of the mandelbrot pipeline. Finished pixel words are
// captured into a RESX x RESY framebuffer in raster order, the stored words
// are fed back to the pipeline (pin) addressed by the pipeline's own xin/yin,
// and every completed frame is streamed out as clamped iteration counts on a
// valid/ready port.
//
// Ports
//   clk          in   single clock, all state updates on posedge
//   rst_n        in   asynchronous active-low reset
//   output_ready in   pout valid this cycle
//   pout         in   finished pixel word, [15:0] = iteration count
//   xin, yin     in   pipeline input coordinates (11 bits each)
//   pin          out  feedback word fb[xin][yin], combinational, 0 if invalid
//   fb_init      out  sticky: at least one full frame has been written
//   frame_done   out  one-cycle pulse after the last pixel of a frame
//   frame_count  out  completed frames, wraps at 16 bits
//   so_valid     out  scan-out pixel valid
//   so_ready     in   scan-out consumer ready
//   so_data      out  min(pixel[15:0], IMAX)
//   so_x, so_y   out  scan-out pixel coordinates
//   so_last      out  high while presenting pixel (RESX-1, RESY-1)
// ---------------------------------------------------------------------------
module mandelbrot_fb_writer #(
  parameter int RESX = 32,
  parameter int RESY = 32,
  parameter int IMAX = 8,
  parameter int PW   = 81
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          output_ready,
  input  logic [PW-1:0] pout,
  input  logic [10:0]   xin,
  input  logic [10:0]   yin,
  output logic [PW-1:0] pin,
  output logic          fb_init,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          so_valid,
  input  logic          so_ready,
  output logic [15:0]   so_data,
  output logic [10:0]   so_x,
  output logic [10:0]   so_y,
  output logic          so_last
);

  localparam int NPIX = RESX * RESY;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [10:0] RESX_W = 11'(RESX);
  localparam logic [10:0] RESY_W = 11'(RESY);
  localparam logic [10:0] XMAX   = 11'(RESX - 1);
  localparam logic [10:0] YMAX   = 11'(RESY - 1);
  localparam logic [15:0] IMAX_W = 16'(IMAX);

  // The origin pixel is also the last one only for a 1x1 frame.
  localparam logic ORIGIN_LAST = ((RESX == 1) && (RESY == 1)) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Linear framebuffer address, row-major (x fastest).
  function automatic logic [AW-1:0] pix_addr(input logic [10:0] x, input logic [10:0] y);
    return AW'(y) * AW'(RESX) + AW'(x);
  endfunction

  // Unsigned saturation of an iteration count to IMAX.
  function automatic logic [15:0] clamp_count(input logic [15:0] cnt);
    return (cnt >= IMAX_W) ? IMAX_W : cnt;
  endfunction

  logic [PW-1:0] fb_mem [NPIX];

  logic [10:0]   wx_r;
  logic [10:0]   wy_r;
  logic          pending_r;
  state_t        state_r;

  logic          x_wrap_s;
  logic          y_wrap_s;
  logic [AW-1:0] wr_addr_s;

  logic [10:0]   so_x_next_s;
  logic [10:0]   so_y_next_s;
  logic          so_last_next_s;
  logic [AW-1:0] so_addr_next_s;
  logic [15:0]   origin_count_s;
  logic [15:0]   next_count_s;

  // Write-side raster position decode.
  always_comb begin
    x_wrap_s  = (wx_r == XMAX);
    y_wrap_s  = (wy_r == YMAX);
    wr_addr_s = pix_addr(wx_r, wy_r);
  end

  // Framebuffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (output_ready) begin
      fb_mem[wr_addr_s] <= pout;
    end
  end

  // Raster write counters, frame bookkeeping and the frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx_r        <= 11'd0;
      wy_r        <= 11'd0;
      fb_init     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      if (output_ready) begin
        if (x_wrap_s) begin
          wx_r <= 11'd0;
          if (y_wrap_s) begin
            wy_r        <= 11'd0;
            fb_init     <= 1'b1;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end else begin
            wy_r <= wy_r + 11'd1;
          end
        end else begin
          wx_r <= wx_r + 11'd1;
        end
      end
    end
  end

  // Feedback read: zero-latency, returns the pre-write word on a same-address
  // write because the array only updates at the clock edge.
  always_comb begin
    pin = '0;
    if (fb_init && (xin < RESX_W) && (yin < RESY_W)) begin
      pin = fb_mem[pix_addr(xin, yin)];
    end else begin
      pin = '0;
    end
  end

  // Next scan-out pixel in raster order and the clamped words to load.
  always_comb begin
    so_x_next_s = so_x + 11'd1;
    so_y_next_s = so_y;
    if (so_x == XMAX) begin
      so_x_next_s = 11'd0;
      so_y_next_s = so_y + 11'd1;
    end else begin
      so_x_next_s = so_x + 11'd1;
      so_y_next_s = so_y;
    end
    so_last_next_s = (so_x_next_s == XMAX) && (so_y_next_s == YMAX);
    so_addr_next_s = pix_addr(so_x_next_s, so_y_next_s);
    origin_count_s = clamp_count(fb_mem[0][15:0]);
    next_count_s   = clamp_count(fb_mem[so_addr_next_s][15:0]);
  end

  // Scan-out FSM with registered stream outputs and a one-deep frame queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      so_valid  <= 1'b0;
      so_data   <= 16'd0;
      so_x      <= 11'd0;
      so_y      <= 11'd0;
      so_last   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_done) begin
            state_r  <= STREAM;
            so_valid <= 1'b1;
            so_x     <= 11'd0;
            so_y     <= 11'd0;
            so_data  <= origin_count_s;
            so_last  <= ORIGIN_LAST;
          end
        end
        STREAM: begin
          if (so_valid && so_ready) begin
            if (so_last) begin
              // A frame_done coinciding with the final beat is treated as queued.
              if (pending_r || frame_done) begin
                pending_r <= 1'b0;
                so_valid  <= 1'b1;
                so_x      <= 11'd0;
                so_y      <= 11'd0;
                so_data   <= origin_count_s;
                so_last   <= ORIGIN_LAST;
              end else begin
                state_r   <= IDLE;
                pending_r <= 1'b0;
                so_valid  <= 1'b0;
                so_last   <= 1'b0;
              end
            end else begin
              so_x    <= so_x_next_s;
              so_y    <= so_y_next_s;
              so_data <= next_count_s;
              so_last <= so_last_next_s;
              if (frame_done) begin
                pending_r <= 1'b1;
              end
            end
          end else if (frame_done) begin
            // Setting an already-set flag drops the extra frame.
            pending_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
          so_valid  <= 1'b0;
          so_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_fb_writer.sv
module tb_mandelbrot_fb_writer;

  localparam int RESX = 32;
  localparam int RESY = 32;
  localparam int IMAX = 8;
  localparam int PW   = 81;
  localparam int NPIX = RESX * RESY;

  logic          clk;
  logic          rst_n;
  logic          output_ready;
  logic [PW-1:0] pout;
  logic [10:0]   xin;
  logic [10:0]   yin;
  logic [PW-1:0] pin;
  logic          fb_init;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          so_valid;
  logic          so_ready;
  logic [15:0]   so_data;
  logic [10:0]   so_x;
  logic [10:0]   so_y;
  logic          so_last;

  int n_checks;
  int n_fail;

  // Scoreboard entries: {data[15:0], x[10:0], y[10:0], last}
  logic [38:0] sb_q[$];

  mandelbrot_fb_writer #(
    .RESX(RESX), .RESY(RESY), .IMAX(IMAX), .PW(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .output_ready(output_ready), .pout(pout),
    .xin(xin), .yin(yin), .pin(pin), .fb_init(fb_init),
    .frame_done(frame_done), .frame_count(frame_count),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data),
    .so_x(so_x), .so_y(so_y), .so_last(so_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pix_val(input int mode, input int i);
    if (mode == 1) return i % 21;
    else if (mode == 2) return (i * 37) % 50;
    else return i;
  endfunction

  function automatic logic [15:0] exp_clamp(input int v);
    return (v >= IMAX) ? 16'(IMAX) : 16'(v);
  endfunction

  task automatic do_reset();
    output_ready = 1'b0;
    so_ready     = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one full frame of pixel words; optionally queue expected scan-out.
  task automatic write_frame(input int mode, input bit push);
    for (int i = 0; i < NPIX; i++) begin
      output_ready = 1'b1;
      pout = {65'd0, 16'(pix_val(mode, i))};
      if (push) sb_q.push_back({exp_clamp(pix_val(mode, i)), 11'(i % RESX), 11'(i / RESX),
                                (i == NPIX - 1) ? 1'b1 : 1'b0});
      @(posedge clk); #1;
    end
    output_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; output_ready = 1'b0; so_ready = 1'b0;
    pout = '0; xin = 11'd0; yin = 11'd0;
    #1;
    n_checks++;
    if ({fb_init, frame_done, frame_count} !== 18'd0) begin
      n_fail++; $display("FAIL reset_frame_state: got %0h expected 0", {fb_init, frame_done, frame_count});
    end
    n_checks++;
    if ({so_valid, so_data, so_x, so_y, so_last} !== 40'd0) begin
      n_fail++; $display("FAIL reset_so_state: got %0h expected 0", {so_valid, so_data, so_x, so_y, so_last});
    end
    n_checks++;
    if (pin !== '0) begin
      n_fail++; $display("FAIL reset_pin: got %0h expected 0", pin);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame_write();
    so_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      output_ready = 1'b1;
      pout = {65'd0, 16'(i)};
      xin = 11'(i % RESX); yin = 11'((7 * i) % RESY);
      @(posedge clk); #1;
      if (i < NPIX - 1) begin
        n_checks++;
        if (frame_done !== 1'b0) begin
          n_fail++; $display("FAIL early_frame_done: beat %0d got %0b expected 0", i, frame_done);
        end
        n_checks++;
        if (pin !== '0) begin
          n_fail++; $display("FAIL pin_before_init: beat %0d got %0h expected 0", i, pin);
        end
      end
    end
    output_ready = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("FAIL frame_done_pulse: got %0b expected 1", frame_done);
    end
    n_checks++;
    if (frame_count !== 16'd1 || fb_init !== 1'b1) begin
      n_fail++; $display("FAIL frame_count_init: got count %0d init %0b expected 1/1", frame_count, fb_init);
    end
    xin = 11'd5; yin = 11'd2; #1;
    n_checks++;
    if (pin !== 81'd69) begin
      n_fail++; $display("FAIL pin_5_2: got %0d expected 69", pin);
    end
    n_checks++;
    if (so_valid !== 1'b0) begin
      n_fail++; $display("FAIL so_valid_early: got %0b expected 0", so_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL frame_done_width: got %0b expected 0", frame_done);
    end
    n_checks++;
    if ({so_valid, so_data, so_x, so_y, so_last} !== {1'b1, 16'd0, 11'd0, 11'd0, 1'b0}) begin
      n_fail++; $display("FAIL so_first_load: got %0h expected %0h", {so_valid, so_data, so_x, so_y, so_last},
                         {1'b1, 16'd0, 11'd0, 11'd0, 1'b0});
    end
  endtask

  task automatic test_gapped_write();
    logic [64:0] tag;
    int c;
    int n;
    bit ov;
    tag = 65'h1_2345_6789_ABCD_EF01;
    do_reset();
    c = 0; n = 0;
    while (n < NPIX) begin
      ov = ((c % 3) != 2);
      output_ready = ov;
      pout = {tag, 16'(n)};
      @(posedge clk); #1;
      if (ov) n++;
      c++;
      if (n < NPIX) begin
        n_checks++;
        if (frame_done !== 1'b0) begin
          n_fail++; $display("FAIL gap_early_frame_done: valid %0d got %0b expected 0", n, frame_done);
        end
      end
    end
    output_ready = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1) begin
      n_fail++; $display("FAIL gap_frame_done: got %0b/%0d expected 1/1", frame_done, frame_count);
    end
    for (int y = 0; y < RESY; y++) begin
      for (int x = 0; x < RESX; x++) begin
        xin = 11'(x); yin = 11'(y); #1;
        n_checks++;
        if (pin !== {tag, 16'(x + RESX * y)}) begin
          n_fail++; $display("FAIL gap_fb_contents: (%0d,%0d) got %0h expected %0h", x, y, pin, {tag, 16'(x + RESX * y)});
        end
      end
    end
  endtask

  task automatic test_scanout_full();
    logic [38:0] exp;
    int cyc;
    do_reset();
    sb_q.delete();
    write_frame(1, 1'b1);
    so_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 3000) begin
      if (so_valid) begin
        exp = sb_q.pop_front();
        n_checks++;
        if ({so_data, so_x, so_y, so_last} !== exp) begin
          n_fail++; $display("FAIL scan_beat: got %0h expected %0h", {so_data, so_x, so_y, so_last}, exp);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scan_timeout: got %0d beats left expected 0", sb_q.size());
    end
    n_checks++;
    if (so_valid !== 1'b0) begin
      n_fail++; $display("FAIL scan_end_idle: got %0b expected 0", so_valid);
    end
  endtask

  task automatic test_random_ready();
    logic [38:0] exp;
    logic [38:0] held;
    bit stalled;
    int cyc;
    do_reset();
    sb_q.delete();
    write_frame(2, 1'b1);
    stalled = 1'b0;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 6000) begin
      if (stalled) begin
        n_checks++;
        if ({so_data, so_x, so_y, so_last} !== held) begin
          n_fail++; $display("FAIL stall_hold: got %0h expected %0h", {so_data, so_x, so_y, so_last}, held);
        end
      end
      so_ready = 1'($urandom_range(0, 1));
      if (so_valid && so_ready) begin
        exp = sb_q.pop_front();
        stalled = 1'b0;
        n_checks++;
        if ({so_data, so_x, so_y, so_last} !== exp) begin
          n_fail++; $display("FAIL rand_beat: got %0h expected %0h", {so_data, so_x, so_y, so_last}, exp);
        end
      end else if (so_valid) begin
        stalled = 1'b1;
        held = {so_data, so_x, so_y, so_last};
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    so_ready = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rand_timeout: got %0d beats left expected 0", sb_q.size());
    end
    n_checks++;
    if (so_valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_end_idle: got %0b expected 0", so_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [38:0] exp;
    int cyc;
    do_reset();
    sb_q.delete();
    write_frame(1, 1'b1);
    write_frame(1, 1'b1);
    write_frame(1, 1'b0);
    n_checks++;
    if (frame_count !== 16'd3) begin
      n_fail++; $display("FAIL b2b_frame_count: got %0d expected 3", frame_count);
    end
    so_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 5000) begin
      n_checks++;
      if (!so_valid) begin
        n_fail++; $display("FAIL b2b_gap: got so_valid 0 expected 1 with %0d beats left", sb_q.size());
      end else begin
        exp = sb_q.pop_front();
        if ({so_data, so_x, so_y, so_last} !== exp) begin
          n_fail++; $display("FAIL b2b_beat: got %0h expected %0h", {so_data, so_x, so_y, so_last}, exp);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d beats left expected 0", sb_q.size());
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (so_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_dropped_frame: cycle %0d got so_valid %0b expected 0", k, so_valid);
      end
      @(posedge clk); #1;
    end
    so_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    logic [38:0] exp;
    int beats;
    int cyc;
    do_reset();
    sb_q.delete();
    write_frame(0, 1'b1);
    so_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 500 && cyc < 2000) begin
      if (so_valid) begin
        exp = sb_q.pop_front();
        beats++;
        n_checks++;
        if ({so_data, so_x, so_y, so_last} !== exp) begin
          n_fail++; $display("FAIL mid_beat: got %0h expected %0h", {so_data, so_x, so_y, so_last}, exp);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({so_valid, fb_init, frame_count} !== 18'd0) begin
      n_fail++; $display("FAIL mid_reset_state: got %0h expected 0", {so_valid, fb_init, frame_count});
    end
    xin = 11'd5; yin = 11'd2; #1;
    n_checks++;
    if (pin !== '0) begin
      n_fail++; $display("FAIL mid_reset_pin: got %0h expected 0", pin);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    so_ready = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    write_frame(0, 1'b0);
    n_checks++;
    if (fb_init !== 1'b1 || frame_count !== 16'd1 || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_frame: got init %0b count %0d done %0b expected 1/1/1",
                         fb_init, frame_count, frame_done);
    end
    xin = 11'd32; yin = 11'd0; #1;
    n_checks++;
    if (pin !== '0) begin
      n_fail++; $display("FAIL pin_x_oob: got %0h expected 0", pin);
    end
    xin = 11'd0; yin = 11'd40; #1;
    n_checks++;
    if (pin !== '0) begin
      n_fail++; $display("FAIL pin_y_oob: got %0h expected 0", pin);
    end
    xin = 11'd31; yin = 11'd31; #1;
    n_checks++;
    if (pin !== 81'd1023) begin
      n_fail++; $display("FAIL pin_corner: got %0d expected 1023", pin);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_frame_write();
    test_gapped_write();
    test_scanout_full();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_fb_writer.md
Name: mandelbrot_fb_writer

Overview:
- Downstream consumer of the mandelbrot pipeline.
- Captures each finished pixel word (output_ready/pout) into a RESX x RESY framebuffer, using raster counters.
- Feeds stored words back to the pipeline's pin input, indexed by the pipeline's current xin/yin.
- After every completed frame, streams clamped iteration counts out on a valid/ready port for display or dump logic.

Parameters:
RESX, 32, frame width in pixels
RESY, 32, frame height in pixels
IMAX, 8, maximum iteration count; so_data clamp value
PW, 81, pixel word width (pout/pin)

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
output_ready  in  1  pout valid this cycle
pout  in  PW  finished pixel word; bits [15:0] hold the iteration count
xin  in  11  pipeline input x coordinate
yin  in  11  pipeline input y coordinate
pin  out  PW  feedback word to pipeline (combinational)
fb_init  out  1  at least one full frame has been written
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
frame_count  out  16  number of completed frames, wraps
so_valid  out  1  scan-out pixel valid
so_ready  in  1  scan-out consumer ready
so_data  out  16  min(pixel[15:0], IMAX)
so_x  out  11  scan-out pixel x
so_y  out  11  scan-out pixel y
so_last  out  1  asserted with pixel (RESX-1, RESY-1)

Behaviour:
- Reset (async assert, sync release): wx, wy, fb_init, frame_done, frame_count, pending and all so_* outputs go to 0. FSM goes to IDLE. Framebuffer contents are not reset.
- Write path:
  - On posedge with output_ready=1, write fb[wx][wy] <= pout.
  - wx increments. At wx==RESX-1, wx wraps to 0 and wy increments.
  - At wx==RESX-1 and wy==RESY-1: wy wraps to 0, fb_init <= 1 (sticky until reset), frame_done <= 1, and frame_count increments (wrapping at 16 bits).
  - frame_done is 0 in every other cycle.
  - When output_ready=0, counters hold and nothing is written.
- Feedback read: pin = fb[xin][yin] when fb_init=1, xin<RESX and yin<RESY. Otherwise pin = 0. The read is combinational with zero latency. Reads in the same cycle as a write to the same address return the old word.
- Scan-out FSM has two states, IDLE and STREAM.
  - IDLE -> STREAM on frame_done=1. On that edge, load so_x=0, so_y=0, so_data=clamp(fb[0][0][15:0]) and so_valid=1. so_valid therefore rises in the cycle after the frame_done pulse.
  - In STREAM, a beat transfers on a posedge with so_valid && so_ready. The next pixel loads in raster order, x fastest. so_last=1 only while presenting (RESX-1, RESY-1).
  - While so_valid=1 and so_ready=0, so_data, so_x, so_y and so_last hold stable.
  - After the last beat transfers: if pending=1, clear pending and reload pixel (0,0), staying in STREAM (so_valid stays 1). Otherwise go to IDLE with so_valid=0.
  - frame_done arriving in STREAM sets pending. Further frame_done pulses while pending=1 are dropped, so at most one queued frame.
  - frame_done on the same edge as the last beat counts as pending, so streaming restarts.
- Scan-out reads live framebuffer contents at the load edge. A frame being overwritten concurrently may mix frames; this is intended.
- Clamp rule: so_data = (pixel[15:0] >= IMAX) ? IMAX : pixel[15:0], as an unsigned compare.
- Reset mid-stream or mid-frame: everything returns to reset values immediately, and the partial frame is discarded.

Test Plan:
1. Reset, then drive 1024 output_ready beats with pout[15:0]=x+32*y:
   - frame_done is high exactly one cycle after the 1024th write edge.
   - frame_count=1 and fb_init=1.
   - xin=5, yin=2 gives pin=69.
   - Before that frame completes, pin=0 for any xin/yin.
2. Same stream with output_ready deasserted every third cycle: identical framebuffer contents; frame_done fires only after the 1024th valid beat.
3. so_ready=1 constantly, stored counts 0..20:
   - 1024 beats, with so_data=min(v,8) (e.g. stored 20 gives 8, stored 3 gives 3).
   - so_last is high only on beat 1024, at so_x=31, so_y=31.
4. so_ready toggled pseudo-randomly: so_data/so_x/so_y hold stable across every stalled cycle; no beat is lost or duplicated.
5. Two frame_done pulses during one stream: exactly one extra 1024-beat stream follows back-to-back, with no so_valid gap; the second pulse is dropped.
6. Assert rst_n=0 mid-stream at beat 500: so_valid, fb_init and frame_count read 0 immediately; xin=32 or yin=40 gives pin=0 even after fb_init=1.
